// File: rtl/sync_sequencer.sv
// sync_sequencer: timing controller for the explosive-experiment board.
// Arms on start, locks onto the frame-grabber opto edge, fires the detonator
// so the blast lands on shutter open, confirms the blast on the wire sensor,
// then triggers the detector and waits for its readout to finish.
// Optional build macro: SYNC_TIMEOUT_EN adds a TIMEOUT-cycle limit to the
// WAIT_WIRE, WAIT_BUSY and WAIT_READY states.
module sync_sequencer #(
   parameter int SYNC_STAGES    = 2,
   parameter int DETONATE_DELAY = 450000,
   parameter int DET_PULSE      = 500,
   parameter int DEBOUNCE       = 50,
   parameter int TRIG_PULSE     = 100,
   parameter int TIMEOUT        = 100000,
   parameter int CNT_W          = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       fg_opto,
   input  logic       wire_sensor,
   input  logic       detector_ready,
   output logic       detonator_trigger,
   output logic       output_trigger,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [2:0] err_code,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_ARMED      = 4'd1,
      S_DELAY      = 4'd2,
      S_FIRE       = 4'd3,
      S_WAIT_WIRE  = 4'd4,
      S_TRIGGER    = 4'd5,
      S_WAIT_BUSY  = 4'd6,
      S_WAIT_READY = 4'd7,
      S_DONE       = 4'd8,
      S_ERROR      = 4'd9
   } state_t;

   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_NOT_READY = 3'd1;
`ifdef SYNC_TIMEOUT_EN
   localparam logic [2:0] ERR_WIRE_TMO  = 3'd2;
   localparam logic [2:0] ERR_BUSY_TMO  = 3'd3;
   localparam logic [2:0] ERR_READY_TMO = 3'd4;
`endif

   // A zero-length delay or pulse is meaningless; treat it as one cycle.
   localparam int NS  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int DLY = (DETONATE_DELAY < 1) ? 1 : DETONATE_DELAY;
   localparam int DPW = (DET_PULSE < 1) ? 1 : DET_PULSE;
   localparam int DEB = (DEBOUNCE < 1) ? 1 : DEBOUNCE;
   localparam int TPW = (TRIG_PULSE < 1) ? 1 : TRIG_PULSE;
   localparam int TMO = (TIMEOUT < 1) ? 1 : TIMEOUT;

   localparam logic [CNT_W-1:0] DLY_C = CNT_W'(DLY);
   localparam logic [CNT_W-1:0] DPW_C = CNT_W'(DPW);
   localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEB);
   localparam logic [CNT_W-1:0] TPW_C = CNT_W'(TPW);
`ifdef SYNC_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TMO);
`endif

   function automatic longint max2(input longint a, input longint b);
      return (a > b) ? a : b;
   endfunction

   localparam longint MAX_P = max2(max2(max2(DLY, DPW), max2(DEB, TPW)), TMO);

   // Refuse to build a counter that would be too narrow for its own limits.
   if (MAX_P > ((longint'(1) << CNT_W) - 1)) begin : g_cnt_w_too_small
      $error("sync_sequencer: CNT_W too narrow for the largest delay parameter");
   end

   // Counters stop at all-ones rather than wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // Bit order in the synchronizer: {start, fg_opto, wire_sensor, detector_ready}
   logic [3:0] sync_q [NS];
   logic [1:0] edge_q;
   logic       start_rise;
   logic       opto_rise;
   logic       wire_s;
   logic       ready_s;

   assign wire_s     = sync_q[NS-1][1];
   assign ready_s    = sync_q[NS-1][0];
   assign start_rise = sync_q[NS-1][3] & ~edge_q[1];
   assign opto_rise  = sync_q[NS-1][2] & ~edge_q[0];

   // Multi-flop synchronizer for every asynchronous input, plus edge history.
   // NOTE: the synchronizer array is flops, not RAM, so it is reset like any
   // other register; a power-up X would otherwise fake an edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NS; i++) sync_q[i] <= '0;
         edge_q <= '0;
      end else begin
         sync_q[0] <= {start, fg_opto, wire_sensor, detector_ready};
         for (int i = 1; i < NS; i++) sync_q[i] <= sync_q[i-1];
         edge_q <= sync_q[NS-1][3:2];
      end
   end

   state_t           cur;
   logic [CNT_W-1:0] cnt;
`ifdef SYNC_TIMEOUT_EN
   logic [CNT_W-1:0] tmo;
`endif

   assign state = cur;

   // Sequencer FSM; every output is registered and set on the transition.
   // NOTE: all state here uses non-blocking assignments so every branch sees
   // the values from before this edge, whatever order the code is written in.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cur               <= S_IDLE;
         cnt               <= '0;
         detonator_trigger <= 1'b0;
         output_trigger    <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
         error             <= 1'b0;
         err_code          <= ERR_NONE;
`ifdef SYNC_TIMEOUT_EN
         tmo               <= '0;
`endif
      end else begin
`ifdef SYNC_TIMEOUT_EN
         // Free-running wait timer; each wait state restarts it on entry.
         tmo <= sat_inc(tmo);
`endif
         case (cur)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start_rise) begin
                  done <= 1'b0;
                  if (!ready_s) begin
                     cur      <= S_ERROR;
                     error    <= 1'b1;
                     err_code <= ERR_NOT_READY;
                  end else begin
                     cur      <= S_ARMED;
                     busy     <= 1'b1;
                     error    <= 1'b0;
                     err_code <= ERR_NONE;
                  end
               end
            end
            S_ARMED: begin
               if (opto_rise) begin
                  cur <= S_DELAY;
                  cnt <= CNT_W'(1);
               end
            end
            S_DELAY: begin
               if (cnt >= DLY_C) begin
                  cur               <= S_FIRE;
                  detonator_trigger <= 1'b1;
                  cnt               <= CNT_W'(1);
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            S_FIRE: begin
               if (cnt >= DPW_C) begin
                  cur               <= S_WAIT_WIRE;
                  detonator_trigger <= 1'b0;
                  cnt               <= '0;
`ifdef SYNC_TIMEOUT_EN
                  tmo               <= CNT_W'(1);
`endif
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            S_WAIT_WIRE: begin
               if (cnt >= DEB_C) begin
                  cur            <= S_TRIGGER;
                  output_trigger <= 1'b1;
                  cnt            <= CNT_W'(1);
               end
`ifdef SYNC_TIMEOUT_EN
               else if (tmo >= TMO_C) begin
                  cur      <= S_ERROR;
                  busy     <= 1'b0;
                  error    <= 1'b1;
                  err_code <= ERR_WIRE_TMO;
               end
`endif
               else if (wire_s) begin
                  cnt <= sat_inc(cnt);
               end else begin
                  cnt <= '0;
               end
            end
            S_TRIGGER: begin
               if (cnt >= TPW_C) begin
                  cur            <= S_WAIT_BUSY;
                  output_trigger <= 1'b0;
                  cnt            <= '0;
`ifdef SYNC_TIMEOUT_EN
                  tmo            <= CNT_W'(1);
`endif
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            S_WAIT_BUSY: begin
               if (!ready_s) begin
                  cur <= S_WAIT_READY;
`ifdef SYNC_TIMEOUT_EN
                  tmo <= CNT_W'(1);
               end else if (tmo >= TMO_C) begin
                  cur      <= S_ERROR;
                  busy     <= 1'b0;
                  error    <= 1'b1;
                  err_code <= ERR_BUSY_TMO;
`endif
               end
            end
            S_WAIT_READY: begin
               if (ready_s) begin
                  cur  <= S_DONE;
                  busy <= 1'b0;
                  done <= 1'b1;
`ifdef SYNC_TIMEOUT_EN
               end else if (tmo >= TMO_C) begin
                  cur      <= S_ERROR;
                  busy     <= 1'b0;
                  error    <= 1'b1;
                  err_code <= ERR_READY_TMO;
`endif
               end
            end
            default: begin
               cur  <= S_IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
